// File: rtl/i2c_master_wr.sv
// Single-clock I2C write initiator: START, address+W, register byte, data byte, STOP.
// SCL is derived from the system clock in quarter-period steps; SDA is driven open-drain.
module i2c_master_wr #(
    parameter int QDIV        = 4,
    parameter int unique_addr = 7,
    parameter int addrs_line  = 8,
    parameter int word_size   = 8
) (
    input  logic                   clk_master,
    input  logic                   reset_master,
    input  logic                   en_master,
    input  logic [unique_addr-1:0] addrs_master,
    input  logic [addrs_line-1:0]  sr_master,
    input  logic [word_size-1:0]   write_master,
    input  logic                   sda_in,
    output logic                   sda_oe,
    output logic                   scl_out,
    output logic                   busy,
    output logic                   done,
    output logic                   nack
);

    localparam int ABYTE = unique_addr + 1;
    localparam int MAXW0 = (ABYTE > addrs_line) ? ABYTE : addrs_line;
    localparam int MAXW  = (MAXW0 > word_size) ? MAXW0 : word_size;
    localparam int BCW   = (MAXW > 1) ? $clog2(MAXW) : 1;
    localparam int TW    = (QDIV > 1) ? $clog2(QDIV) : 1;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_START = 4'd1,
        S_ADDR  = 4'd2,
        S_ACK_A = 4'd3,
        S_REG   = 4'd4,
        S_ACK_R = 4'd5,
        S_DATA  = 4'd6,
        S_ACK_D = 4'd7,
        S_STOP  = 4'd8
    } state_t;

    state_t                 state_q, state_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [1:0]             quarter_q, quarter_d;
    logic [BCW-1:0]         bit_q, bit_d;
    logic [unique_addr-1:0] addr_q, addr_d;
    logic [addrs_line-1:0]  reg_q, reg_d;
    logic [word_size-1:0]   data_q, data_d;
    logic                   ack_q, ack_d;
    logic                   scl_q, scl_d;
    logic                   sda_oe_q, sda_oe_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   nack_q, nack_d;
    logic                   tick_s;
    logic                   last_s;
    logic                   cur_bit_s;

    // Bit to place on SDA for a given shifting state and bit index (MSB first).
    function automatic logic tx_bit(input state_t st, input logic [BCW-1:0] idx,
                                    input logic [unique_addr-1:0] a,
                                    input logic [addrs_line-1:0] r,
                                    input logic [word_size-1:0] w);
        logic [MAXW-1:0] vec;
        vec = '0;
        case (st)
            S_ADDR:  vec[ABYTE-1:0]      = {a, 1'b0};
            S_REG:   vec[addrs_line-1:0] = r;
            S_DATA:  vec[word_size-1:0]  = w;
            default: vec = '0;
        endcase
        return vec[idx];
    endfunction

    // Next-state logic: quarter timing, byte sequencing and ACK evaluation.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        quarter_d = quarter_q;
        bit_d     = bit_q;
        addr_d    = addr_q;
        reg_d     = reg_q;
        data_d    = data_q;
        ack_d     = ack_q;
        nack_d    = nack_q;
        done_d    = 1'b0;
        tick_s    = (timer_q == TW'(QDIV - 1));
        last_s    = tick_s && (quarter_q == 2'd3);

        if (state_q == S_IDLE) begin
            timer_d   = '0;
            quarter_d = 2'd0;
            if (en_master) begin
                addr_d  = addrs_master;
                reg_d   = sr_master;
                data_d  = write_master;
                nack_d  = 1'b0;
                ack_d   = 1'b0;
                state_d = S_START;
            end else begin
                state_d = S_IDLE;
            end
        end else if (tick_s) begin
            timer_d   = '0;
            quarter_d = quarter_q + 2'd1;
        end else begin
            timer_d   = timer_q + TW'(1);
        end

        case (state_q)
            S_IDLE: begin
                bit_d = '0;
            end
            S_START: begin
                if (last_s) begin
                    state_d = S_ADDR;
                    bit_d   = BCW'(ABYTE - 1);
                end else begin
                    bit_d   = bit_q;
                end
            end
            S_ADDR, S_REG, S_DATA: begin
                if (last_s && (bit_q == '0)) begin
                    state_d = (state_q == S_ADDR) ? S_ACK_A :
                              (state_q == S_REG)  ? S_ACK_R : S_ACK_D;
                end else if (last_s) begin
                    bit_d   = bit_q - BCW'(1);
                end else begin
                    bit_d   = bit_q;
                end
            end
            S_ACK_A, S_ACK_R, S_ACK_D: begin
                // sda_in is captured on the edge that enters q3 (SCL already high).
                if (tick_s && (quarter_q == 2'd2)) begin
                    ack_d  = sda_in;
                    nack_d = nack_q | sda_in;
                end else begin
                    ack_d  = ack_q;
                end
                if (last_s && (ack_q || (state_q == S_ACK_D))) begin
                    state_d = S_STOP;
                end else if (last_s && (state_q == S_ACK_A)) begin
                    state_d = S_REG;
                    bit_d   = BCW'(addrs_line - 1);
                end else if (last_s) begin
                    state_d = S_DATA;
                    bit_d   = BCW'(word_size - 1);
                end else begin
                    state_d = state_q;
                end
            end
            S_STOP: begin
                if (last_s) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    done_d  = 1'b0;
                end
            end
            default: begin
                state_d   = S_IDLE;
                timer_d   = '0;
                quarter_d = 2'd0;
            end
        endcase
    end

    // Bus levels for the upcoming cycle, derived from the next state so they register in step.
    always_comb begin
        busy_d    = (state_d != S_IDLE);
        cur_bit_s = tx_bit(state_d, bit_d, addr_d, reg_d, data_d);
        scl_d     = 1'b1;
        sda_oe_d  = 1'b0;
        case (state_d)
            S_IDLE: begin
                scl_d    = 1'b1;
                sda_oe_d = 1'b0;
            end
            S_START: begin
                scl_d    = 1'b1;
                sda_oe_d = quarter_d[1];
            end
            S_ADDR, S_REG, S_DATA: begin
                scl_d    = quarter_d[1];
                sda_oe_d = (quarter_d == 2'd0) ? sda_oe_q : ~cur_bit_s;
            end
            S_ACK_A, S_ACK_R, S_ACK_D: begin
                scl_d    = quarter_d[1];
                sda_oe_d = (quarter_d == 2'd0) ? sda_oe_q : 1'b0;
            end
            S_STOP: begin
                scl_d    = quarter_d[1];
                sda_oe_d = (quarter_d != 2'd3);
            end
            default: begin
                scl_d    = 1'b1;
                sda_oe_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_master) begin
        if (reset_master) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            quarter_q <= 2'd0;
            bit_q     <= '0;
            addr_q    <= '0;
            reg_q     <= '0;
            data_q    <= '0;
            ack_q     <= 1'b0;
            scl_q     <= 1'b1;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            nack_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            quarter_q <= quarter_d;
            bit_q     <= bit_d;
            addr_q    <= addr_d;
            reg_q     <= reg_d;
            data_q    <= data_d;
            ack_q     <= ack_d;
            scl_q     <= scl_d;
            sda_oe_q  <= sda_oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            nack_q    <= nack_d;
        end
    end

    assign scl_out = scl_q;
    assign sda_oe  = sda_oe_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign nack    = nack_q;

endmodule

// File: tb/tb_i2c_master_wr.sv
// Directed bench for i2c_master_wr: one instance at QDIV=4, one at QDIV=1, with a simple ACKing slave.
module tb_i2c_master_wr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rst_v = 2'b11;
    logic [1:0] en_v  = 2'b00;
    logic [1:0] sda_in_v, sda_oe_v, scl_v, busy_v, done_v, nack_v, pull_v;
    logic [6:0] addr_s = 7'h00;
    logic [7:0] sr_s   = 8'h00;
    logic [7:0] wr_s   = 8'h00;

    int cyc      = 0;
    int n_checks = 0;
    int n_fail   = 0;

    int fall_cnt [2] = '{0, 0};
    int rise_cnt [2] = '{0, 0};
    int start_cnt[2] = '{0, 0};
    int stop_cnt [2] = '{0, 0};
    int t_acc    [2] = '{0, 0};
    int lat      [2] = '{0, 0};
    int run      [2] = '{0, 0};
    int done_seen[2] = '{0, 0};
    int hi_min   [2] = '{0, 0};
    int hi_max   [2] = '{0, 0};
    int lo_min   [2] = '{0, 0};
    int lo_max   [2] = '{0, 0};
    logic [31:0] cap     [2] = '{32'h0, 32'h0};
    logic        scl_p   [2] = '{1'b1, 1'b1};
    logic        sda_p   [2] = '{1'b1, 1'b1};
    logic        busy_p  [2] = '{1'b0, 1'b0};
    logic        hi_valid[2] = '{1'b0, 1'b0};
    logic [2:0]  ack_pat [2] = '{3'b111, 3'b111};

    i2c_master_wr #(.QDIV(4)) dut4 (
        .clk_master(clk), .reset_master(rst_v[0]), .en_master(en_v[0]),
        .addrs_master(addr_s), .sr_master(sr_s), .write_master(wr_s),
        .sda_in(sda_in_v[0]), .sda_oe(sda_oe_v[0]), .scl_out(scl_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .nack(nack_v[0])
    );

    i2c_master_wr #(.QDIV(1)) dut1 (
        .clk_master(clk), .reset_master(rst_v[1]), .en_master(en_v[1]),
        .addrs_master(addr_s), .sr_master(sr_s), .write_master(wr_s),
        .sda_in(sda_in_v[1]), .sda_oe(sda_oe_v[1]), .scl_out(scl_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .nack(nack_v[1])
    );

    // Slave pulls SDA low during ACK bits 8, 17, 26 (bit b starts at SCL fall number b+1).
    always @* begin
        for (int i = 0; i < 2; i++) begin
            pull_v[i] = busy_v[i] & (((fall_cnt[i] == 9)  & ack_pat[i][0]) |
                                     ((fall_cnt[i] == 18) & ack_pat[i][1]) |
                                     ((fall_cnt[i] == 27) & ack_pat[i][2]));
        end
    end
    assign sda_in_v = ~(sda_oe_v | pull_v);

    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor: samples on the falling clock edge, away from DUT updates.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (busy_v[i] === 1'b1 && !busy_p[i]) begin
                t_acc[i] = cyc; fall_cnt[i] = 0; rise_cnt[i] = 0; cap[i] = 32'h0;
                start_cnt[i] = 0; stop_cnt[i] = 0; run[i] = 0; hi_valid[i] = 1'b0;
                hi_min[i] = 1000; hi_max[i] = 0; lo_min[i] = 1000; lo_max[i] = 0;
            end
            if (busy_v[i] === 1'b1) begin
                if (scl_p[i] && scl_v[i]) begin
                    if (sda_p[i] && !sda_in_v[i]) start_cnt[i]++;
                    if (!sda_p[i] && sda_in_v[i]) stop_cnt[i]++;
                end
                if (!scl_p[i] && scl_v[i]) begin
                    cap[i] = {cap[i][30:0], sda_in_v[i]};
                    rise_cnt[i]++;
                    if (run[i] < lo_min[i]) lo_min[i] = run[i];
                    if (run[i] > lo_max[i]) lo_max[i] = run[i];
                    hi_valid[i] = 1'b1;
                    run[i] = 1;
                end else if (scl_p[i] && !scl_v[i]) begin
                    fall_cnt[i]++;
                    if (hi_valid[i]) begin
                        if (run[i] < hi_min[i]) hi_min[i] = run[i];
                        if (run[i] > hi_max[i]) hi_max[i] = run[i];
                    end
                    run[i] = 1;
                end else begin
                    run[i]++;
                end
            end
            if (done_v[i] === 1'b1) begin
                lat[i] = cyc - t_acc[i];
                done_seen[i]++;
            end
            scl_p[i]  = scl_v[i];
            sda_p[i]  = sda_in_v[i];
            busy_p[i] = (busy_v[i] === 1'b1);
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_done(input int d, input int budget);
        logic got;
        got = 1'b0;
        for (int k = 0; k < budget && !got; k++) begin
            @(negedge clk);
            if (done_v[d] === 1'b1) got = 1'b1;
        end
        #1;
        check_eq("done_seen_in_time", got, 1'b1);
    endtask

    task automatic start_txn(input int d, input logic [6:0] a, input logic [7:0] s,
                             input logic [7:0] w, input logic [2:0] pat);
        ack_pat[d]   = pat;
        done_seen[d] = 0;
        addr_s = a; sr_s = s; wr_s = w;
        en_v[d] = 1'b1;
        @(negedge clk);
        en_v[d] = 1'b0;
        #1;
        check_eq("accept_busy", {busy_v[d], nack_v[d]}, 2'b10);
    endtask

    task automatic verify(input int d, input string tag, input int exp_lat,
                          input logic [31:0] exp_cap, input int exp_rise,
                          input logic exp_nack, input int exp_phase);
        check_eq({tag, "_latency"}, lat[d], exp_lat);
        check_eq({tag, "_sda_bits"}, cap[d], exp_cap);
        check_eq({tag, "_scl_rises"}, rise_cnt[d], exp_rise);
        check_eq({tag, "_start_stop"}, {16'(start_cnt[d]), 16'(stop_cnt[d])}, {16'd1, 16'd1});
        check_eq({tag, "_nack_busy"}, {nack_v[d], busy_v[d]}, {exp_nack, 1'b0});
        check_eq({tag, "_scl_phases"},
                 {16'(hi_min[d]), 16'(hi_max[d]), 16'(lo_min[d]), 16'(lo_max[d])},
                 {4{16'(exp_phase)}});
        @(negedge clk);
        #1;
        check_eq({tag, "_done_pulse"}, {done_v[d], 8'(done_seen[d])}, {1'b0, 8'd1});
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_eq("reset_q4", {scl_v[0], sda_oe_v[0], busy_v[0], done_v[0], nack_v[0]}, 5'b10000);
        check_eq("reset_q1", {scl_v[1], sda_oe_v[1], busy_v[1], done_v[1], nack_v[1]}, 5'b10000);
        rst_v = 2'b00;
        repeat (2) @(negedge clk);

        // Full write D0/03/A5, all ACKed: 116 quarters * 4 clocks.
        start_txn(0, 7'b1101000, 8'h03, 8'hA5, 3'b111);
        wait_done(0, 600);
        verify(0, "full", 464, 32'h0D001A94, 28, 1'b0, 8);

        // Address NACK: D0, NACK bit (1), then only the STOP rise.
        start_txn(0, 7'b1101000, 8'h03, 8'hA5, 3'b000);
        wait_done(0, 600);
        verify(0, "addr_nack", 176, 32'h00000342, 10, 1'b1, 8);

        // Register NACK: D0, ACK, 03, NACK, STOP rise.
        start_txn(0, 7'b1101000, 8'h03, 8'hA5, 3'b001);
        wait_done(0, 600);
        verify(0, "reg_nack", 320, 32'h0006800E, 19, 1'b1, 8);

        // Data NACK: full length, last ACK bit reads 1.
        start_txn(0, 7'b1101000, 8'h03, 8'hA5, 3'b011);
        wait_done(0, 600);
        verify(0, "data_nack", 464, 32'h0D001A96, 28, 1'b1, 8);

        // en held high, inputs changed mid-transaction; nack must clear on acceptance.
        ack_pat[0] = 3'b111;
        done_seen[0] = 0;
        addr_s = 7'b1101000; sr_s = 8'h03; wr_s = 8'hA5;
        en_v[0] = 1'b1;
        @(negedge clk);
        #1;
        check_eq("hold_nack_cleared", {busy_v[0], nack_v[0]}, 2'b10);
        repeat (100) @(negedge clk);
        addr_s = 7'h2A; sr_s = 8'h55; wr_s = 8'h11;
        wait_done(0, 600);
        verify(0, "hold_first", 464, 32'h0D001A94, 28, 1'b0, 8);
        check_eq("back_to_back_busy", busy_v[0], 1'b1);
        en_v[0] = 1'b0;
        done_seen[0] = 0;
        wait_done(0, 600);
        verify(0, "hold_second", 464, 32'h0542A844, 28, 1'b0, 8);

        // Reset while the register byte is being shifted.
        start_txn(0, 7'b1101000, 8'h03, 8'hA5, 3'b111);
        begin
            logic reached;
            reached = 1'b0;
            for (int k = 0; k < 600 && !reached; k++) begin
                @(negedge clk);
                if (fall_cnt[0] >= 12) reached = 1'b1;
            end
            check_eq("reached_reg_byte", reached, 1'b1);
        end
        rst_v[0] = 1'b1;
        @(negedge clk);
        #1;
        check_eq("mid_reset", {scl_v[0], sda_oe_v[0], busy_v[0], done_v[0], nack_v[0]}, 5'b10000);
        rst_v[0] = 1'b0;
        @(negedge clk);
        start_txn(0, 7'b1101000, 8'h03, 8'hA5, 3'b111);
        wait_done(0, 600);
        verify(0, "after_reset", 464, 32'h0D001A94, 28, 1'b0, 8);

        // QDIV=1: 116 clocks, 2-clock SCL high/low phases.
        start_txn(1, 7'b1101000, 8'h03, 8'hA5, 3'b111);
        wait_done(1, 200);
        verify(1, "qdiv1", 116, 32'h0D001A94, 28, 1'b0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        n_fail++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
